// File: rtl/fp_from_int.sv
// Iterative 32-bit signed integer to custom float (sign, 6-bit exponent, 25-bit mantissa).
// One normalization shift per cycle, start/done handshake, truncating rounding.
module fp_from_int #(
  parameter int BIAS = 31
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic signed [31:0] int_in,
  output logic               busy,
  output logic               done,
  output logic [31:0]        data_out,
  output logic [3:0]         status_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    PACK = 2'd2
  } state_t;

  localparam logic [5:0] EXP_INIT = 6'(BIAS + 31);

  state_t      state;
  logic        sign_r;
  logic [31:0] mag;
  logic [5:0]  exp_r;

  // The most negative input has no positive twin; its bit pattern is already the magnitude.
  function automatic logic [31:0] abs_mag(input logic signed [31:0] v);
    logic [31:0] u;
    u = $unsigned(v);
    return v[31] ? (~u + 32'd1) : u;
  endfunction

  function automatic logic [31:0] pack_word(input logic s, input logic [5:0] e,
                                            input logic [31:0] m);
    return (m == 32'd0) ? 32'd0 : {s, e, m[30:6]};
  endfunction

  function automatic logic [3:0] trunc_status(input logic [5:0] dropped);
    return (|dropped) ? 4'b1111 : 4'b0001;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_out   <= 32'd0;
      status_out <= 4'b0000;
      sign_r     <= 1'b0;
      mag        <= 32'd0;
      exp_r      <= 6'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_r <= int_in[31];
            mag    <= abs_mag(int_in);
            exp_r  <= EXP_INIT;
            busy   <= 1'b1;
            state  <= NORM;
          end
        end
        NORM: begin
          if (mag == 32'd0 || mag[31]) begin
            state <= PACK;
          end else begin
            mag   <= mag << 1;
            exp_r <= exp_r - 6'd1;
          end
        end
        PACK: begin
          data_out   <= pack_word(sign_r, exp_r, mag);
          status_out <= trunc_status(mag[5:0]);
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_from_int.sv
// Bench for fp_from_int: vector table plus handshake, busy-ignore and async-reset sequences.
module tb_fp_from_int;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic signed [31:0] int_in;
  logic               busy;
  logic               done;
  logic [31:0]        data_out;
  logic [3:0]         status_out;

  fp_from_int #(.BIAS(31)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .int_in     (int_in),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out),
    .status_out (status_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  st;
    int          lat;
    int          stamp;
  } exp_t;

  typedef struct {
    logic [31:0] val;
    logic [31:0] data;
    logic [3:0]  st;
    int          lat;
  } vec_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Scoreboard side: every done pops the oldest expected result.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done actual data=%h expected no done", data_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("data", data_out, e.data);
        check("status", {28'd0, status_out}, {28'd0, e.st});
        check("latency", 32'(cyc - e.stamp - 1), 32'(e.lat));
        check("busy_in_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // Called at posedge+1; holds start for one edge and returns at posedge+1.
  task automatic kick(input logic [31:0] v, input logic [31:0] d, input logic [3:0] st,
                      input int lat);
    exp_t e;
    e.data  = d;
    e.st    = st;
    e.lat   = lat;
    e.stamp = cyc;
    q.push_back(e);
    start  = 1'b1;
    int_in = v;
    @(posedge clock); #1;
    start  = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(posedge clock);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL done_timeout actual pending=%0d expected 0", q.size());
      q.delete();
    end
  endtask

  vec_t vecs[10];
  int   held_bad;
  logic seen;

  initial begin
    vecs[0] = '{32'h00000001, 32'h3E000000, 4'b0001, 33};
    vecs[1] = '{32'hFFFFFFFF, 32'hBE000000, 4'b0001, 33};
    vecs[2] = '{32'h00000006, 32'h43000000, 4'b0001, 31};
    vecs[3] = '{32'h00000000, 32'h00000000, 4'b0001, 2};
    vecs[4] = '{32'h80000000, 32'hFC000000, 4'b0001, 2};
    vecs[5] = '{32'h7FFFFFFF, 32'h7BFFFFFF, 4'b1111, 3};
    vecs[6] = '{32'hFFFFFFFA, 32'hC3000000, 4'b0001, 31};
    vecs[7] = '{32'h02000000, 32'h70000000, 4'b0001, 8};
    vecs[8] = '{32'h02000001, 32'h70000001, 4'b0001, 8};
    vecs[9] = '{32'h04000001, 32'h72000000, 4'b1111, 7};

    reset  = 1'b0;
    start  = 1'b0;
    int_in = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_data", data_out, 32'd0);
    check("reset_status", {28'd0, status_out}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      kick(vecs[i].val, vecs[i].data, vecs[i].st, vecs[i].lat);
      wait_empty(60);
    end

    // Back-to-back: second start issued in the done cycle of the first.
    @(posedge clock); #1;
    kick(32'd1, 32'h3E000000, 4'b0001, 33);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin @(posedge clock); #1; end
    end
    check("b2b_first_done_seen", {31'd0, seen}, 32'd1);
    kick(32'd6, 32'h43000000, 4'b0001, 31);
    held_bad = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (data_out !== 32'h3E000000) held_bad++;
      @(posedge clock); #1;
    end
    check("b2b_first_held", 32'(held_bad), 32'd0);
    wait_empty(5);

    // Starts while busy must be ignored.
    @(posedge clock); #1;
    kick(32'd1, 32'h3E000000, 4'b0001, 33);
    for (int i = 0; i < 5; i++) begin
      start  = 1'b1;
      int_in = $urandom;
      @(posedge clock); #1;
      start  = 1'b0;
      @(posedge clock); #1;
    end
    wait_empty(60);
    repeat (5) @(posedge clock);

    // Asynchronous reset in the middle of normalization.
    #1;
    kick(32'd1, 32'h3E000000, 4'b0001, 33);
    repeat (10) @(posedge clock);
    #1;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    q.delete();
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_data", data_out, 32'd0);
    check("midreset_status", {28'd0, status_out}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (40) @(posedge clock);
    #1;
    kick(32'hFFFFFFFF, 32'hBE000000, 4'b0001, 33);
    wait_empty(60);

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_from_int.md
# fp_from_int

Iterative converter from a 32-bit two's-complement integer to the team's 32-bit custom float format: sign `[31]`, exponent `[30:25]` with bias 31, and a 25-bit mantissa `[24:0]` with an implicit leading 1. It is the encoder that produces operands for the FPU adder. It uses the same status encoding, so its outputs feed `op_A_in`/`op_B_in` directly. Normalization is a one-bit-per-cycle shift state machine with a start/done handshake.

## Interface
- `BIAS`, default 31: exponent bias. Exponent field = unbiased exponent + `BIAS`.
- `clock` input, 1 bit: clock; all state changes on the rising edge.
- `reset` input, 1 bit: reset, asynchronous, active-low.
- `start` input, 1 bit: request a conversion. Sampled only in IDLE.
- `int_in` input, 32 bits: signed integer operand. Sampled on the edge that accepts `start`.
- `busy` output, 1 bit: high in NORM and PACK.
- `done` output, 1 bit: registered one-cycle pulse; result is valid from this cycle on.
- `data_out` output, 32 bits: float result. Held until the next PACK.
- `status_out` output, 4 bits: `4'b0001` exact, `4'b1111` inexact (truncated bits nonzero). Held with `data_out`.

## Operation
- States: IDLE, NORM, PACK (2-bit encoding).
- **IDLE, `start`=1:**
  - `sign_r` <= `int_in[31]`.
  - `mag` <= |`int_in`| as 32-bit unsigned; `0x80000000` yields magnitude `0x80000000`.
  - `exp_r` <= `BIAS`+31 (62).
  - Go to NORM.
- **IDLE, `start`=0:** stay in IDLE.
- **NORM:**
  - If `mag`==0, go to PACK.
  - Else if `mag[31]`==1, go to PACK.
  - Else `mag` <= `mag`<<1, `exp_r` <= `exp_r`-1, stay in NORM.
- **PACK:**
  - If `mag`==0: `data_out` <= 0 (sign dropped, +0), `status_out` <= `0001`.
  - Else: `data_out` <= {`sign_r`, `exp_r[5:0]`, `mag[30:6]`}; `status_out` <= `|mag[5:0]` ? `1111` : `0001`.
  - `done` <= 1, go to IDLE.
- Rounding is truncation toward zero of the magnitude. Magnitudes below 2^25 are always exact.
- Exponent range is 31..62. Overflow and underflow cannot occur, and codes `0011`/`0111` are never produced.
- `start` while `busy` is ignored. There is no queueing, and `int_in` changes during a conversion have no effect.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `data_out` 0, `status_out` `0000`, internal registers 0.
- `start` is accepted on edge T. Let p = index of the magnitude MSB and n = 31-p:
  - NORM occupies n+1 cycles.
  - PACK occupies 1 cycle.
  - `done` is high in the cycle after edge T+n+2, i.e. latency n+2 cycles (2..33).
- Zero input: latency 2.
- `done` is high for exactly one cycle, and the FSM is in IDLE during that cycle. A `start` in the `done` cycle is accepted (back-to-back conversions, no bubble).
- `busy` rises the cycle after acceptance and falls in the `done` cycle.
- Asynchronous reset mid-conversion: immediately IDLE, all outputs at reset values, conversion discarded, no `done`.

## Test plan
- `int_in`=1 -> `data_out`=`0x3E000000`, `status_out`=`0001`, `done` 33 cycles after `start`. `int_in`=-1 -> `0xBE000000`, `0001`.
- `int_in`=6 -> `0x43000000`, `0001`, latency 31. `int_in`=0 -> `0x00000000`, `0001`, latency 2.
- `int_in`=`0x80000000` -> `0xFC000000`, `0001`, latency 2. `int_in`=`0x7FFFFFFF` -> `0x7BFFFFFF`, `1111`, latency 3.
- Back-to-back: pulse `start` with 1, then assert `start` with 6 in the `done` cycle. Expect a second `done` 31 cycles later with `0x43000000`; the first result holds until then.
- `start` pulsed repeatedly with other values while `busy` -> ignored; the result matches the originally sampled `int_in`.
- `reset` low during NORM of `int_in`=1 -> outputs 0 immediately, no `done`. After release, a new `start` with -1 yields `0xBE000000`.
